seq_stream_scan_ctrl: RTL

//  Controller that feeds a serial bit-pattern detector from a parallel word stream.
//  - Accepts DATA_W-bit words over a valid/ready handshake.
//  - Serialises each word MSB-first, one bit per clock, into a PAT_W-bit overlapping pattern matcher.
//  - Counts matches and raises a sticky threshold interrupt.
//  - Sits between a word-wide producer (bus/FIFO) and the serial detection datapath.

---
 rtl/seq_stream_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seq_stream_scan_ctrl.sv
// Word-to-bit serialiser feeding a PAT_W-bit pattern matcher with a saturating match counter
// and a sticky threshold irq. Define NONOVERLAP_EN for non-overlapping match detection.
module seq_stream_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   word_r, word_s;
  logic [PAT_W-1:0]    pat_r, pat_s;
  logic [PAT_W-1:0]    hist_r, hist_s;
  logic [FILL_W-1:0]   fill_r, fill_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                match_r, match_s;
  logic                irq_r, irq_s;
  logic                in_ready_r, in_ready_s;
  logic                busy_r, busy_s;
  logic                bit_s;
  logic [PAT_W-1:0]    shifted_s;
  logic [FILL_W-1:0]   fill_inc_s;
  logic                hit_s;

  // Candidate history and fill for the bit being shifted this cycle.
  always_comb begin
    bit_s      = word_r[idx_r];
    shifted_s  = {hist_r[PAT_W-2:0], bit_s};
    fill_inc_s = (fill_r == FILL_MAX) ? fill_r : (fill_r + FILL_W'(1));
    hit_s      = (shifted_s == pat_r) && (fill_inc_s == FILL_MAX);
  end

  // Next-state and next-output logic; clear overrides any accept or match.
  always_comb begin
    state_s  = state_r;
    word_s   = word_r;
    pat_s    = pat_r;
    hist_s   = hist_r;
    fill_s   = fill_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    match_s  = 1'b0;
    irq_s    = irq_r;
    if (clear) begin
      state_s = IDLE;
      hist_s  = {PAT_W{1'b0}};
      fill_s  = {FILL_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
      irq_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            word_s  = in_data;
            pat_s   = cfg_pattern;
            idx_s   = IDX_TOP;
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          hist_s = shifted_s;
          fill_s = fill_inc_s;
          if (hit_s) begin
            match_s = 1'b1;
            cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));
`ifdef NONOVERLAP_EN
            hist_s  = {PAT_W{1'b0}};
            fill_s  = {FILL_W{1'b0}};
`endif
          end else begin
            match_s = 1'b0;
          end
          if (idx_r == {IDX_W{1'b0}}) begin
            state_s = IDLE;
          end else begin
            idx_s = idx_r - IDX_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
      // irq follows the registered count, so it lands one cycle after the count crosses.
      irq_s = irq_r | ((cfg_thresh != {CNT_W{1'b0}}) && (cnt_r >= cfg_thresh));
    end
    in_ready_s = (state_s == IDLE);
    busy_s     = (state_s == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      word_r     <= {DATA_W{1'b0}};
      pat_r      <= {PAT_W{1'b0}};
      hist_r     <= {PAT_W{1'b0}};
      fill_r     <= {FILL_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      match_r    <= 1'b0;
      irq_r      <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_r     <= word_s;
      pat_r      <= pat_s;
      hist_r     <= hist_s;
      fill_r     <= fill_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      match_r    <= match_s;
      irq_r      <= irq_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign match     = match_r;
  assign match_cnt = cnt_r;
  assign irq       = irq_r;

endmodule
